// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter.
// Latches a WIDTH-bit pattern and an 8-bit repetition count on start, then
// shifts the pattern out one bit per clock, count times, with GAP idle
// cycles between repetitions. done pulses in the final (DONE) cycle.
// All outputs are flops loaded from the next-state decode, so they line up
// with the state they describe without any combinational path to the pins.
module sequence_generator #(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [7:0]       count,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pat_q,   pat_d;
    logic [7:0]       rep_q,   rep_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic [3:0]       gap_q,   gap_d;
    logic             out_q,   out_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [WIDTH-1:0] shift_adv;

    // Shift register advanced by one slot in the configured bit order.
    always_comb begin
        shift_adv = shift_q;
        if (MSB_FIRST) begin
            shift_adv = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_adv = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    // Next-state logic and registered-output decode of the next state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        bit_d   = bit_q;
        gap_d   = gap_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = pattern;
                    pat_d   = pattern;
                    rep_d   = count;
                    bit_d   = BIT_LAST;
                    gap_d   = '0;
                    state_d = (count != 8'd0) ? S_SEND : S_DONE;
                end
            end
            S_SEND: begin
                if (bit_q == '0) begin
                    if (rep_q != 8'd0) begin
                        rep_d = rep_q - 8'd1;
                    end
                    if (rep_q > 8'd1) begin
                        if (GAP > 0) begin
                            gap_d   = GAP_LAST;
                            state_d = S_GAP;
                        end else begin
                            // No gap: reload and keep sending without a bubble.
                            shift_d = pat_q;
                            bit_d   = BIT_LAST;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    shift_d = shift_adv;
                    bit_d   = bit_q - BW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    shift_d = pat_q;
                    bit_d   = BIT_LAST;
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_SEND);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        out_d   = 1'b0;
        if (state_d == S_SEND) begin
            out_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
        end
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: scoreboard bench for sequence_generator.
// Three instances cover MSB-first with gap, LSB-first with gap, and
// MSB-first without gap. Expected {out,valid,busy,done} per cycle are
// pushed into a queue when stimulus is applied and popped each cycle.
module tb_sequence_generator;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_a, start_b, start_c;
    logic [3:0] pattern;
    logic [7:0] count;
    logic       out_a, valid_a, busy_a, done_a;
    logic       out_b, valid_b, busy_b, done_b;
    logic       out_c, valid_c, busy_c, done_c;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    always #5 clock = ~clock;

    sequence_generator #(.WIDTH(4), .GAP(1), .MSB_FIRST(1'b1)) u_a (
        .clock(clock), .reset(reset), .start(start_a), .pattern(pattern), .count(count),
        .out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a));

    sequence_generator #(.WIDTH(4), .GAP(1), .MSB_FIRST(1'b0)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .pattern(pattern), .count(count),
        .out(out_b), .valid(valid_b), .busy(busy_b), .done(done_b));

    sequence_generator #(.WIDTH(4), .GAP(0), .MSB_FIRST(1'b1)) u_c (
        .clock(clock), .reset(reset), .start(start_c), .pattern(pattern), .count(count),
        .out(out_c), .valid(valid_c), .busy(busy_c), .done(done_c));

    // Sequence detector for 1101 fed directly by generator A's serial output.
    logic [3:0] det_hist_q;
    logic       det_hit;
    always_ff @(posedge clock) begin
        if (reset) det_hist_q <= '0;
        else       det_hist_q <= {det_hist_q[2:0], out_a};
    end
    assign det_hit = (det_hist_q == 4'b1101);

    // Expected per-cycle outputs of one transmission plus the IDLE cycle after it.
    task automatic push_tx(input logic [3:0] pat, input int cnt, input int gap, input bit msb);
        if (cnt == 0) begin
            exp_q.push_back(4'b0011);
        end else begin
            for (int r = 0; r < cnt; r++) begin
                for (int b = 0; b < 4; b++) begin
                    exp_q.push_back({msb ? pat[3-b] : pat[b], 3'b110});
                end
                if (r != cnt - 1) begin
                    for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
                end
            end
            exp_q.push_back(4'b0011);
        end
        exp_q.push_back(4'b0000);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        pattern = 4'b1101; count = 8'd2;
        @(negedge clock); @(negedge clock);
        checks++;
        if ({out_a, valid_a, busy_a, done_a} !== 4'b0000) begin
            errors++; $display("FAIL reset_a: got %b want 0000", {out_a, valid_a, busy_a, done_a});
        end
        checks++;
        if ({out_b, valid_b, busy_b, done_b} !== 4'b0000) begin
            errors++; $display("FAIL reset_b: got %b want 0000", {out_b, valid_b, busy_b, done_b});
        end
        checks++;
        if ({out_c, valid_c, busy_c, done_c} !== 4'b0000) begin
            errors++; $display("FAIL reset_c: got %b want 0000", {out_c, valid_c, busy_c, done_c});
        end
        // start together with reset must be dropped
        start_a = 1'b1;
        @(negedge clock);
        reset = 1'b0; start_a = 1'b0;
        checks++;
        if ({out_a, valid_a, busy_a, done_a} !== 4'b0000) begin
            errors++; $display("FAIL reset_start: got %b want 0000", {out_a, valid_a, busy_a, done_a});
        end
        @(negedge clock);
        checks++;
        if ({out_a, valid_a, busy_a, done_a} !== 4'b0000) begin
            errors++; $display("FAIL reset_start_after: got %b want 0000", {out_a, valid_a, busy_a, done_a});
        end
    endtask

    task automatic test_basic();
        logic [10:0] lo, lv, lb, ld;
        logic [3:0]  e;
        lo = 11'b11010110100;
        lv = 11'b11110111100;
        lb = 11'b11111111110;
        ld = 11'b00000000010;
        exp_q.delete();
        for (int i = 0; i < 11; i++) exp_q.push_back({lo[10-i], lv[10-i], lb[10-i], ld[10-i]});
        pattern = 4'b1101; count = 8'd2; start_a = 1'b1;
        for (int c = 1; c <= 20 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (c == 1) start_a = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({out_a, valid_a, busy_a, done_a} !== e) begin
                errors++; $display("FAIL basic cycle %0d: got %b want %b", c, {out_a, valid_a, busy_a, done_a}, e);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL basic timeout: %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] e;
        exp_q.delete();
        pattern = 4'b1101; count = 8'd2; start_b = 1'b1;
        push_tx(4'b1101, 2, 1, 1'b0);
        for (int c = 1; c <= 20 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (c == 1) start_b = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({out_b, valid_b, busy_b, done_b} !== e) begin
                errors++; $display("FAIL lsb cycle %0d: got %b want %b", c, {out_b, valid_b, busy_b, done_b}, e);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL lsb timeout: %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_no_gap();
        logic [3:0] e;
        exp_q.delete();
        pattern = 4'b1101; count = 8'd3; start_c = 1'b1;
        push_tx(4'b1101, 3, 0, 1'b1);
        for (int c = 1; c <= 30 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (c == 1) start_c = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({out_c, valid_c, busy_c, done_c} !== e) begin
                errors++; $display("FAIL nogap cycle %0d: got %b want %b", c, {out_c, valid_c, busy_c, done_c}, e);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL nogap timeout: %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_count_zero();
        logic [3:0] e;
        exp_q.delete();
        pattern = 4'b1111; count = 8'd0; start_a = 1'b1;
        push_tx(4'b1111, 0, 1, 1'b1);
        for (int c = 1; c <= 10 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            if (c == 1) start_a = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({out_a, valid_a, busy_a, done_a} !== e) begin
                errors++; $display("FAIL count0 cycle %0d: got %b want %b", c, {out_a, valid_a, busy_a, done_a}, e);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL count0 timeout: %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        exp_q.delete();
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        push_tx(4'b1101, 2, 1, 1'b1);
        pattern = 4'b1101; count = 8'd2; start_a = 1'b1;
        for (int c = 1; c <= 30 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({out_a, valid_a, busy_a, done_a} !== e) begin
                errors++; $display("FAIL reset_mid cycle %0d: got %b want %b", c, {out_a, valid_a, busy_a, done_a}, e);
            end
            if (c == 1) start_a = 1'b0;
            if (c == 3) reset = 1'b1;
            if (c == 4) reset = 1'b0;
            if (c == 5) start_a = 1'b1;
            if (c == 6) start_a = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL reset_mid timeout: %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        exp_q.delete();
        push_tx(4'b1101, 2, 1, 1'b1);
        push_tx(4'b0010, 2, 1, 1'b1);
        pattern = 4'b1101; count = 8'd2; start_a = 1'b1;
        for (int c = 1; c <= 40 && exp_q.size() > 0; c++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if ({out_a, valid_a, busy_a, done_a} !== e) begin
                errors++; $display("FAIL b2b cycle %0d: got %b want %b", c, {out_a, valid_a, busy_a, done_a}, e);
            end
            if (c == 3) pattern = 4'b0010;
            if (c == 5) count = 8'd7;
            if (c == 9) count = 8'd2;
            if (c == 12) start_a = 1'b0;
            if (c == 14) begin pattern = 4'b1111; count = 8'd9; end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b timeout: %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_loopback();
        logic [11:0] stream;
        logic        eh;
        stream = 12'b110101101000;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({det_hit, out_a} !== 2'b00) begin
            errors++; $display("FAIL loop_reset: got %b want 00", {det_hit, out_a});
        end
        reset = 1'b0; pattern = 4'b1101; count = 8'd2; start_a = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (c == 1) start_a = 1'b0;
            eh = (c == 5) || (c == 10);
            checks++;
            if ({out_a, det_hit} !== {stream[12-c], eh}) begin
                errors++; $display("FAIL loop cycle %0d: got out=%b hit=%b want out=%b hit=%b",
                                   c, out_a, det_hit, stream[12-c], eh);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lsb_first();
        test_no_gap();
        test_count_zero();
        test_reset_mid();
        test_back_to_back();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
